// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional odd parity, one stop bit.
// Optional parity bit is generated when the macro TX_PARITY_EN is defined (8O1), otherwise 8N1.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 19_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] din,
    output logic       tx_out,
    output logic       busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
`ifdef TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    data;
    logic          timed;
    logic          bit_done;

    always_comb begin
        timed = (state == S_START) || (state == S_DATA) || (state == S_STOP);
`ifdef TX_PARITY_EN
        if (state == S_PARITY) timed = 1'b1;
`endif
        bit_done = timed && (baud_cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data     <= '0;
        end else begin
            // Every state change coincides with bit_done or an untimed state, so this also clears on transitions.
            baud_cnt <= (timed && !bit_done) ? baud_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    if (send) begin
                        state  <= S_START;
                        data   <= din;
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        tx_out  <= data[0];
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_out  <= data[bit_cnt + 3'd1];
                        end else begin
`ifdef TX_PARITY_EN
                            state  <= S_PARITY;
                            tx_out <= ~(^data);
`else
                            state  <= S_STOP;
                            tx_out <= 1'b1;
`endif
                        end
                    end
                end
`ifdef TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        state  <= S_STOP;
                        tx_out <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    tx_out <= 1'b1;
                    if (bit_done) begin
                        state <= S_WAIT;
                        busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A send still held high from the last frame must not retrigger.
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    if (!send) state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: randomized bytes compared against a frame-level line model.
module tb_uart_tx;
    localparam int BD = 10;
`ifdef TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FBITS = 10 + P;
    localparam int FLEN  = FBITS * BD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk(clk), .reset(reset), .send(send), .din(din), .tx_out(tx_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected line level t cycles after the acceptance edge (t=0 is the acceptance edge itself).
    function automatic logic model_line(input logic [7:0] d, input int t);
        int b;
        b = t / BD;
        if (t >= FLEN) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (P == 1 && b == 9) return ~(^d);
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int t);
        return (t >= 0 && t < FLEN);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; send = 1'b1; din = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d tx_out=%b busy=%b expected tx_out=1 busy=0", i, tx_out, busy);
            end
        end
        reset = 1'b1; send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d tx_out=%b busy=%b expected tx_out=1 busy=0", i, tx_out, busy);
            end
        end
        send = 1'b1;
        tick();
        send = 1'b0;
        vectors++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_start tx_out=%b busy=%b expected tx_out=0 busy=1", tx_out, busy);
        end
        repeat (FLEN + 1) tick();
    endtask

    task automatic test_single_frame();
        logic [7:0] d = 8'hA5;
        int busy_cycles = 0;
        din = d; send = 1'b1;
        for (int t = 0; t <= FLEN; t++) begin
            tick();
            if (t == 0) send = 1'b0;
            busy_cycles += int'(busy);
            vectors++;
            if (tx_out !== model_line(d, t) || busy !== model_busy(t)) begin
                miscompares++;
                $display("FAIL single_frame t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         t, tx_out, busy, model_line(d, t), model_busy(t));
            end
        end
        vectors++;
        if (busy_cycles != FLEN) begin
            miscompares++;
            $display("FAIL busy_length got=%0d expected=%0d", busy_cycles, FLEN);
        end
        tick();
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] d;
            int w;
            d = 8'($urandom);
            w = int'($urandom_range(1, 3));
            din = d; send = 1'b1;
            for (int t = 0; t <= FLEN; t++) begin
                tick();
                if (t == w - 1) send = 1'b0;
                if (t == 5) din = 8'($urandom);
                vectors++;
                if (tx_out !== model_line(d, t) || busy !== model_busy(t)) begin
                    miscompares++;
                    $display("FAIL random_frame d=%h t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                             d, t, tx_out, busy, model_line(d, t), model_busy(t));
                end
            end
            tick();
        end
    endtask

    task automatic test_held_send();
        din = 8'h00; send = 1'b1;
        for (int t = 0; t < 300; t++) begin
            tick();
            vectors++;
            if (tx_out !== model_line(8'h00, t) || busy !== model_busy(t)) begin
                miscompares++;
                $display("FAIL held_send t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         t, tx_out, busy, model_line(8'h00, t), model_busy(t));
            end
        end
        send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL held_release cyc=%0d tx_out=%b busy=%b expected tx_out=1 busy=0", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        d1 = 8'($urandom);
        din = d1; send = 1'b1;
        for (int t = 0; t <= FLEN; t++) begin
            tick();
            if (t == 0) send = 1'b0;
            vectors++;
            if (tx_out !== model_line(d1, t) || busy !== model_busy(t)) begin
                miscompares++;
                $display("FAIL b2b_first t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         t, tx_out, busy, model_line(d1, t), model_busy(t));
            end
        end
        tick();
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
        end
        din = 8'hFF; send = 1'b1;
        for (int t = 0; t <= FLEN; t++) begin
            tick();
            if (t == 0) send = 1'b0;
            vectors++;
            if (tx_out !== model_line(8'hFF, t) || busy !== model_busy(t)) begin
                miscompares++;
                $display("FAIL b2b_second t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         t, tx_out, busy, model_line(8'hFF, t), model_busy(t));
            end
        end
        tick();
    endtask

    task automatic test_din_change();
        din = 8'h3C; send = 1'b1;
        for (int t = 0; t <= FLEN; t++) begin
            tick();
            if (t == 0) send = 1'b0;
            if (t == 24) din = 8'hC3;
            vectors++;
            if (tx_out !== model_line(8'h3C, t) || busy !== model_busy(t)) begin
                miscompares++;
                $display("FAIL din_change t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         t, tx_out, busy, model_line(8'h3C, t), model_busy(t));
            end
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'($urandom);
        din = d; send = 1'b1;
        for (int t = 0; t < 45; t++) begin
            tick();
            if (t == 0) send = 1'b0;
            vectors++;
            if (tx_out !== model_line(d, t) || busy !== model_busy(t)) begin
                miscompares++;
                $display("FAIL mid_reset_pre t=%0d tx_out=%b busy=%b expected tx_out=%b busy=%b",
                         t, tx_out, busy, model_line(d, t), model_busy(t));
            end
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_edge tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_idle cyc=%0d tx_out=%b busy=%b expected tx_out=1 busy=0", i, tx_out, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_held_send();
        test_back_to_back();
        test_din_change();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART datapath; drives the outgoing line that the receive side samples.
- Accepts a byte plus a level-sensitive `send` request, typically from the debounced send button, and emits one frame: start bit, 8 data bits LSB first, optional odd parity bit, stop bit.
- Output is registered so the line never glitches.
- One transmission per assertion of `send`; `send` must return low before the next frame is accepted.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 19_200, line bit rate in bits/s.
- BAUD_DIV is derived, not overridable: BAUD_DIV = CLK_FREQ / BAUD_RATE, integer division, result ≥ 2. The baud counter is $clog2(BAUD_DIV) bits wide.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on posedge clk.
- send  input  1  transmit request, level-sensitive.
- din  input  8  byte to transmit; sampled only on frame acceptance.
- tx_out  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is on the line; registered.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, tx_out=1, busy=0, baud counter=0, bit counter=0.
  - Overrides every other input.
  - Mid-frame reset aborts the frame; the line returns high on that same edge.
- States: IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP, WAIT.
- Baud timer: counts 0..BAUD_DIV-1 while in START/DATA/PARITY/STOP. Its terminal count `bit_done` ends the current bit; the counter clears on every state change and in IDLE/WAIT.
- IDLE → START: when send==1 at edge k.
  - din is latched into a shift register at edge k.
  - tx_out=0 and busy=1 from edge k onward.
  - No latency cycles between acceptance and the start bit.
- START: held BAUD_DIV cycles; on bit_done → DATA, tx_out=din[0], bit counter=0.
- DATA: each bit held BAUD_DIV cycles, LSB first.
  - On bit_done with bit counter<7: increment the counter and output the next bit.
  - On bit_done with bit counter==7: → PARITY (if enabled) else → STOP.
- PARITY: tx_out = ~^data, so total ones across data and parity are odd; held BAUD_DIV cycles, then → STOP.
- STOP: tx_out=1 for BAUD_DIV cycles; on bit_done → WAIT, busy=0 on that edge.
- WAIT: tx_out=1, busy=0.
  - If send==0, → IDLE.
  - A send still held high never starts a second frame.
- Frame length: (10 + P) × BAUD_DIV cycles from the acceptance edge to the edge busy falls, where P=1 with parity enabled and 0 otherwise.
- din changes while busy: ignored; the latched copy is transmitted.
- send dropping mid-frame: ignored; the frame completes, WAIT falls through to IDLE on the next edge.
- send==1 and reset==0 on the same edge: reset wins; nothing is accepted.
- Illegal/unused state encodings: return to IDLE with tx_out=1, busy=0.

Optional Feature:
- Macro TX_PARITY_EN.
- Defined: PARITY state present; odd parity bit between data and stop; frame is 11 bits.
- Undefined: PARITY state and parity logic not generated; DATA goes directly to STOP; frame is 10 bits (8N1).

Test Plan:
- Bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BAUD_DIV=10.
- Reset: hold reset=0 for 3 cycles with send=1 → tx_out=1, busy=0 throughout; no start bit after release until send is re-sampled.
- Single frame, din=8'hA5, send pulsed 1 cycle:
  - tx_out sequence, 10 cycles per bit: 0,1,0,1,0,0,1,0,1, then parity 1 (A5 has 4 ones), then stop 1.
  - busy high exactly 110 cycles, or 100 cycles without TX_PARITY_EN.
- Held send: send=1 for 300 cycles, din=8'h00 → exactly one frame with parity bit 1; busy low after the frame; no second start bit until send drops and rises again.
- Back-to-back: send low 1 cycle after busy falls, then high with din=8'hFF → second frame starts on the acceptance edge, data all 1s, parity 0.
- Data change mid-frame: din switches 8'h3C→8'hC3 at cycle 25 → line still carries 3C bits.
- Mid-frame reset: reset=0 at cycle 45 of a frame → tx_out=1 and busy=0 on that edge; after release with send=0 the line stays idle high.
